// File: rtl/multi_button_debouncer.sv
// ----------------------------------------------------------------------------
// multi_button_debouncer
//
// Debounces a bank of N_CH push buttons. Each channel is fully independent:
//   raw pin -> polarity map -> 2-FF synchroniser -> stability counter ->
//   debounced level, with press/release pulses and a long-press hold timer.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   btn_in     : raw asynchronous button pins (N_CH)
//   btn_state  : debounced level, 1 = pressed
//   btn_down   : 1-cycle pulse when the debounced level rises
//   btn_up     : 1-cycle pulse when the debounced level falls
//   btn_long   : 1-cycle pulse once a press has lasted HOLD_CYCLES edges
//   btn_held   : level, set with btn_long, cleared when the button releases
//   any_event  : OR of every btn_down/btn_up/btn_long bit (combinational)
// ----------------------------------------------------------------------------
module multi_button_debouncer #(
    parameter int N_CH        = 4,
    parameter int CNT_W       = 16,
    parameter int ACTIVE_LOW  = 1,
    parameter int HOLD_CYCLES = 1000000
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_state,
    output logic [N_CH-1:0] btn_down,
    output logic [N_CH-1:0] btn_up,
    output logic [N_CH-1:0] btn_long,
    output logic [N_CH-1:0] btn_held,
    output logic            any_event
);

    localparam int                HOLD_W    = $clog2(HOLD_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(HOLD_CYCLES);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    // Map every pin to "1 = pressed" before it enters the synchroniser, so
    // the reset value 0 of the sync flops always means "not pressed".
    logic [N_CH-1:0] w_pressed;
    assign w_pressed = (ACTIVE_LOW != 0) ? ~btn_in : btn_in;

    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
        logic              r_sync0;
        logic              r_sync1;
        logic              r_state;
        logic              r_down;
        logic              r_up;
        logic              r_long;
        logic              r_held;
        logic [CNT_W-1:0]  r_cnt;
        logic [HOLD_W-1:0] r_hold;

        logic w_idle;
        logic w_flip;
        logic w_fall;
        logic w_long_hit;

        // The counter only runs while the synchronised pin disagrees with
        // the debounced level; a full wrap of disagreement flips the level.
        assign w_idle     = (r_sync1 == r_state);
        assign w_flip     = !w_idle && (r_cnt == CNT_MAX);
        assign w_fall     = w_flip && r_state;
        // Hold timer saturates at HOLD_MAX, so this matches once per press.
        assign w_long_hit = r_state && (r_hold == HOLD_LAST);

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync0 <= 1'b0;
                r_sync1 <= 1'b0;
                r_state <= 1'b0;
                r_down  <= 1'b0;
                r_up    <= 1'b0;
                r_long  <= 1'b0;
                r_held  <= 1'b0;
                r_cnt   <= '0;
                r_hold  <= '0;
            end else begin
                r_sync0 <= w_pressed[gi];
                r_sync1 <= r_sync0;

                r_cnt <= w_idle ? '0 : r_cnt + 1'b1;

                if (w_flip) begin
                    r_state <= ~r_state;
                end
                r_down <= w_flip && !r_state;
                r_up   <= w_fall;

                // A release still inside its debounce window keeps the
                // timer running, because the debounced level is still 1.
                if (!r_state) begin
                    r_hold <= '0;
                end else if (r_hold != HOLD_MAX) begin
                    r_hold <= r_hold + 1'b1;
                end
                r_long <= w_long_hit;

                // Release wins over a coincident long-press hit.
                if (w_fall) begin
                    r_held <= 1'b0;
                end else if (w_long_hit) begin
                    r_held <= 1'b1;
                end
            end
        end

        assign btn_state[gi] = r_state;
        assign btn_down[gi]  = r_down;
        assign btn_up[gi]    = r_up;
        assign btn_long[gi]  = r_long;
        assign btn_held[gi]  = r_held;
    end

    assign any_event = |(btn_down | btn_up | btn_long);

endmodule

// File: tb/tb_multi_button_debouncer.sv
// ----------------------------------------------------------------------------
// tb_multi_button_debouncer
//
// Bench for multi_button_debouncer with N_CH=4, CNT_W=2, ACTIVE_LOW=1,
// HOLD_CYCLES=8. A table of per-cycle vectors covers reset, a plain press,
// its release and a rejected bounce; hand-written sequences cover the
// long-press, simultaneous-press and reset-mid-press cases; a randomized
// run is checked every cycle against a behavioural model.
// ----------------------------------------------------------------------------
module tb_multi_button_debouncer;

    localparam int N    = 4;
    localparam int CW   = 2;
    localparam int WIN  = 1 << CW;   // consecutive differing samples needed
    localparam int HOLD = 8;

    logic         clk;
    logic         rst_n;
    logic [N-1:0] btn;
    logic [N-1:0] btn_state;
    logic [N-1:0] btn_down;
    logic [N-1:0] btn_up;
    logic [N-1:0] btn_long;
    logic [N-1:0] btn_held;
    logic         any_event;

    multi_button_debouncer #(
        .N_CH       (N),
        .CNT_W      (CW),
        .ACTIVE_LOW (1),
        .HOLD_CYCLES(HOLD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .btn_in   (btn),
        .btn_state(btn_state),
        .btn_down (btn_down),
        .btn_up   (btn_up),
        .btn_long (btn_long),
        .btn_held (btn_held),
        .any_event(any_event)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 60)
                $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    // The debounced level flips once WIN consecutive synchronised samples
    // (each two edges old) disagree with it; a press lasting HOLD edges
    // after the level rose produces one long pulse.
    logic [N-1:0] m_state, m_down, m_up, m_long, m_held;
    int           m_run   [N];
    int           m_since [N];
    logic [N-1:0] m_hist  [$];

    task automatic model_reset();
        m_state = '0; m_down = '0; m_up = '0; m_long = '0; m_held = '0;
        for (int c = 0; c < N; c++) begin
            m_run[c]   = 0;
            m_since[c] = 0;
        end
        m_hist.delete();
    endtask

    task automatic model_edge();
        logic [N-1:0] d;
        logic         was;
        if (!rst_n) begin
            model_reset();
            return;
        end
        m_hist.push_back(~btn);
        if (m_hist.size() > 4) void'(m_hist.pop_front());
        d = (m_hist.size() >= 3) ? m_hist[m_hist.size() - 3] : '0;
        m_down = '0; m_up = '0; m_long = '0;
        for (int c = 0; c < N; c++) begin
            was = m_state[c];
            if (d[c] != was) m_run[c]++;
            else             m_run[c] = 0;
            if (was) begin
                if (m_since[c] < HOLD) begin
                    m_since[c]++;
                    if (m_since[c] == HOLD) begin
                        m_long[c] = 1'b1;
                        m_held[c] = 1'b1;
                    end
                end
            end else begin
                m_since[c] = 0;
            end
            if (m_run[c] == WIN) begin
                m_run[c]   = 0;
                m_state[c] = !was;
                if (was) begin
                    m_up[c]   = 1'b1;
                    m_held[c] = 1'b0;
                end else begin
                    m_down[c] = 1'b1;
                end
            end
        end
    endtask

    // One clock edge: advance the model, then compare 1 time unit later.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("mdl_state", 32'(btn_state), 32'(m_state));
        chk("mdl_down",  32'(btn_down),  32'(m_down));
        chk("mdl_up",    32'(btn_up),    32'(m_up));
        chk("mdl_long",  32'(btn_long),  32'(m_long));
        chk("mdl_held",  32'(btn_held),  32'(m_held));
        chk("mdl_any",   32'(any_event), 32'(|(m_down | m_up | m_long)));
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [N-1:0] btn;
        logic [N-1:0] st;
        logic [N-1:0] dn;
        logic [N-1:0] up;
        logic         any;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic [N-1:0] b, input logic [N-1:0] s,
                       input logic [N-1:0] d, input logic [N-1:0] u, input logic a);
        vec_t v;
        v.btn = b; v.st = s; v.dn = d; v.up = u; v.any = a;
        tbl.push_back(v);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, j, cnt, anyc, anyr;
        logic [N-1:0] dn_seen;
        int dur [N];

        // reset with all pins released (active-low: 1 = released)
        btn   = 4'hF;
        rst_n = 1'b0;
        model_reset();
        repeat (3) tick();
        rst_n = 1'b1;

        // reset state: 20 quiet cycles
        for (int i = 0; i < 20; i++) add(4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
        // ch0 press: level and pulse on the 6th edge sampling it
        for (int i = 0; i < 5; i++)  add(4'hE, 4'h0, 4'h0, 4'h0, 1'b0);
        add(4'hE, 4'h1, 4'h1, 4'h0, 1'b1);
        add(4'hE, 4'h1, 4'h0, 4'h0, 1'b0);
        // ch0 release: level falls on the 6th edge sampling it
        for (int i = 0; i < 5; i++)  add(4'hF, 4'h1, 4'h0, 4'h0, 1'b0);
        add(4'hF, 4'h0, 4'h0, 4'h1, 1'b1);
        for (int i = 0; i < 4; i++)  add(4'hF, 4'h0, 4'h0, 4'h0, 1'b0);
        // ch1 bounce: 3 low samples are one short of the window
        for (int i = 0; i < 3; i++)  add(4'hD, 4'h0, 4'h0, 4'h0, 1'b0);
        for (int i = 0; i < 7; i++)  add(4'hF, 4'h0, 4'h0, 4'h0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            btn = tbl[i].btn;
            tick();
            chk("tbl_state", 32'(btn_state), 32'(tbl[i].st));
            chk("tbl_down",  32'(btn_down),  32'(tbl[i].dn));
            chk("tbl_up",    32'(btn_up),    32'(tbl[i].up));
            chk("tbl_long",  32'(btn_long),  32'h0);
            chk("tbl_held",  32'(btn_held),  32'h0);
            chk("tbl_any",   32'(any_event), 32'(tbl[i].any));
            $display("row %0d btn=%h state=%h down=%h up=%h any=%b",
                     i, btn, btn_state, btn_down, btn_up, any_event);
        end

        // ch2 long press
        btn = 4'hB;
        for (k = 1; k <= 20; k++) begin
            tick();
            if (btn_state[2]) break;
        end
        chk("t4_rise_latency", 32'(k), 32'd6);
        for (j = 1; j <= 20; j++) begin
            tick();
            if (btn_long[2]) break;
        end
        chk("t4_long_delay", 32'(j), 32'(HOLD));
        chk("t4_held_set", 32'(btn_held[2]), 32'd1);
        cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            cnt += int'(btn_long[2]);
        end
        chk("t4_single_long", 32'(cnt), 32'd0);
        btn = 4'hF;
        for (k = 1; k <= 20; k++) begin
            tick();
            if (btn_up[2]) break;
        end
        chk("t4_up_latency", 32'(k), 32'd6);
        chk("t4_held_clear", 32'(btn_held[2]), 32'd0);
        $display("long press ch2: rise=6 long after %0d edges, released", j);
        repeat (8) tick();

        // ch0 and ch3 pressed in the same cycle
        btn     = 4'h6;
        anyc    = 0;
        dn_seen = '0;
        j       = 0;
        for (k = 1; k <= 10; k++) begin
            tick();
            anyc += int'(any_event);
            if (btn_down != '0 && dn_seen == '0) begin
                dn_seen = btn_down;
                j       = k;
            end
        end
        chk("t5_down_vec", 32'(dn_seen), 32'h9);
        chk("t5_down_edge", 32'(j), 32'd6);
        chk("t5_any_once", 32'(anyc), 32'd1);
        $display("simultaneous press: down=%h at edge %0d, any_event cycles=%0d", dn_seen, j, anyc);
        btn = 4'hF;
        repeat (12) tick();

        // ch1 pressed, reset mid-count
        btn = 4'hD;
        repeat (3) tick();
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t6_reset_async", 32'({btn_state, btn_down, btn_up, btn_held}), 32'h0);
        anyr = 0;
        repeat (2) begin
            tick();
            anyr += int'(any_event);
        end
        rst_n = 1'b1;
        for (k = 1; k <= 10; k++) begin
            tick();
            anyr += int'(btn_up != '0 || btn_long != '0);
            if (btn_down[1]) break;
        end
        chk("t6_down_after_reset", 32'(k), 32'd6);
        chk("t6_no_other_pulse", 32'(anyr), 32'd0);
        $display("reset mid-press ch1: down %0d edges after release", k);
        btn = 4'hF;
        repeat (12) tick();

        // randomized bouncing pins with occasional resets
        for (int c = 0; c < N; c++) dur[c] = 1;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int c = 0; c < N; c++) begin
                dur[c]--;
                if (dur[c] <= 0) begin
                    btn[c] = ~btn[c];
                    dur[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(5, 24))
                                                          : int'($urandom_range(1, 4));
                end
            end
            if ($urandom_range(0, 599) == 0) begin
                rst_n = 1'b0;
                model_reset();
                tick();
                rst_n = 1'b1;
            end
            tick();
            if (cyc % 500 == 499)
                $display("random segment to cycle %0d: vectors=%0d", cyc + 1, n_vec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
